// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, decoded-control record.
// Latency: n/a (types, constants and a pure combinational decode function only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // LSB positions of the instruction fields (opcode/funct are 6 bits, regs 5, imm 16)
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic       rd_rs;    // instruction reads rs
    logic       rd_rt;    // instruction reads rt
    logic       wr_en;    // instruction writes a non-zero register
    logic [4:0] wr_addr;  // destination, 0 when wr_en=0
    logic       illegal;  // unknown opcode
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] instr);
    dec_ctrl_t  c;
    logic [4:0] dest;
    logic       writes;
    c      = '0;
    dest   = '0;
    writes = 1'b0;
    case (instr[OPC_LSB +: 6])
      OP_RTYPE: begin
        c.rd_rs = 1'b1;
        c.rd_rt = 1'b1;
        writes  = 1'b1;
        dest    = instr[RD_LSB +: 5];
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        c.rd_rs = 1'b1;
        writes  = 1'b1;
        dest    = instr[RT_LSB +: 5];
      end
      OP_SW, OP_BEQ: begin
        c.rd_rs = 1'b1;
        c.rd_rt = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    // r0 is hardwired: a write to it is dropped and never tracked
    if (writes && (dest != 5'd0)) begin
      c.wr_en   = 1'b1;
      c.wr_addr = dest;
    end
    return c;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 always 0.
// Latency: set/clear take effect at the clock edge; pending is the registered vector.
// Backpressure: none; set has priority over both clears of the same register.
// Ports: clk, rst_n; set_en/set_addr (issue of a writer); clr_en/clr_addr (writeback);
//        flush_clr_en/flush_clr_addr (discarded writer); pending[31:0] output.
module issue_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [4:0]  set_addr,
  input  logic        clr_en,
  input  logic [4:0]  clr_addr,
  input  logic        flush_clr_en,
  input  logic [4:0]  flush_clr_addr,
  output logic [31:0] pending
);

  logic [31:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en)       pending_nxt[clr_addr]       = 1'b0;
    if (flush_clr_en) pending_nxt[flush_clr_addr] = 1'b0;
    // applied last so a same-edge set beats a writeback clear
    if (set_en)       pending_nxt[set_addr]       = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes, reads operands, stalls on RAW/WAW hazards, issues to execute.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: in_ready drops on hazard, flush, or a held output not taken by out_ready.
// Ports: clk, rst_n; in_valid/in_ready/in_instr from fetch; rd1/rd2 addr/data to the
//        register file; wb_en/wb_addr writeback; flush; out_valid/out_ready plus out_* fields.
module decode_issue_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rd1_addr,
  output logic [4:0]  rd2_addr,
  input  logic [31:0] rd1_data,
  input  logic [31:0] rd2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [31:0] out_imm,
  output logic        out_wr_en,
  output logic [4:0]  out_wr_addr,
  output logic        out_illegal
);

  dec_ctrl_t   ctrl;
  logic [31:0] pending;
  logic        hazard;
  logic        accept;

  assign ctrl     = decode_ctrl(in_instr);
  assign rd1_addr = in_instr[RS_LSB +: 5];
  assign rd2_addr = in_instr[RT_LSB +: 5];

  // Registered vector only: a writeback this cycle unblocks issue next cycle.
  assign hazard = in_valid && ((ctrl.rd_rs && pending[rd1_addr]) ||
                               (ctrl.rd_rt && pending[rd2_addr]) ||
                               (ctrl.wr_en && pending[ctrl.wr_addr]));

  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  issue_scoreboard u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_en         (accept && ctrl.wr_en),
    .set_addr       (ctrl.wr_addr),
    .clr_en         (wb_en),
    .clr_addr       (wb_addr),
    // a flushed writer will never write back, so release its register here
    .flush_clr_en   (flush && out_valid && out_wr_en),
    .flush_clr_addr (out_wr_addr),
    .pending        (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_funct   <= '0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_imm     <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_opcode  <= in_instr[OPC_LSB +: 6];
      out_funct   <= in_instr[FUNCT_LSB +: 6];
      out_op_a    <= rd1_data;
      out_op_b    <= rd2_data;
      out_imm     <= {{16{in_instr[IMM_LSB + 15]}}, in_instr[IMM_LSB +: 16]};
      out_wr_en   <= ctrl.wr_en;
      out_wr_addr <= ctrl.wr_addr;
      out_illegal <= ctrl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rd1_addr, rd2_addr;
  logic [31:0] rd1_data, rd2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode, out_funct;
  logic [31:0] out_op_a, out_op_b, out_imm;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic        out_illegal;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        illegal;
  } exp_t;

  exp_t obs, exp_v, held;
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always_comb obs = {out_opcode, out_funct, out_op_a, out_op_b, out_imm,
                     out_wr_en, out_wr_addr, out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] opc, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic we,
                              input logic [4:0] wa, input logic ill);
    return {opc, fn, a, b, imm, we, wa, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL reset_pending got=%h required=0", dut.pending); end
    n_cmp++; if (obs !== exp_t'(0)) begin n_err++; $display("FAIL reset_fields got=%h required=0", obs); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rtype();
    out_ready = 1'b0;
    in_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    rd1_data = 32'd5; rd2_data = 32'd7; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rtype_ready got=%b required=1", in_ready); end
    sbq.push_back(mk(6'h00, 6'h20, 32'd5, 32'd7, 32'h0000_1820, 1'b1, 5'd3, 1'b0));
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL rtype_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL rtype_issue got=%h required=%h", obs, exp_v); end
    end
    n_cmp++; if (dut.pending !== 32'h8) begin n_err++; $display("FAIL rtype_pending got=%h required=00000008", dut.pending); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rtype_drain got=%b required=0", out_valid); end
    wb_en = 1'b1; wb_addr = 5'd3;
    tick();
    wb_en = 1'b0;
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL rtype_wb_clear got=%h required=0", dut.pending); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_instr = {6'h08, 5'd0, 5'd4, 16'h0010};
    rd1_data = 32'd100; rd2_data = 32'd200; in_valid = 1'b1;
    #1;
    sbq.push_back(mk(6'h08, 6'h10, 32'd100, 32'd200, 32'h10, 1'b1, 5'd4, 1'b0));
    tick();
    in_instr = {6'h00, 5'd4, 5'd1, 5'd5, 5'd0, 6'h20};
    rd1_data = 32'd11; rd2_data = 32'd22;
    #1;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL addi_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL addi_issue got=%h required=%h", obs, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall cycle %0d got=%b required=0", i, in_ready); end
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd4;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL wb_no_bypass got=%b required=0", in_ready); end
    tick();
    wb_en = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got=%b required=1", in_ready); end
    sbq.push_back(mk(6'h00, 6'h20, 32'd11, 32'd22, 32'h0000_2820, 1'b1, 5'd5, 1'b0));
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL stalled_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL stalled_issue got=%h required=%h", obs, exp_v); end
    end
    n_cmp++; if (dut.pending !== 32'h20) begin n_err++; $display("FAIL stalled_pending got=%h required=00000020", dut.pending); end
    tick();
    wb_en = 1'b1; wb_addr = 5'd5;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_instr = {6'h0D, 5'd2, 5'd7, 16'h8001};
    rd1_data = 32'hA5A5_0000; rd2_data = 32'h0000_1234; in_valid = 1'b1;
    #1;
    held = mk(6'h0D, 6'h01, 32'hA5A5_0000, 32'h0000_1234, 32'hFFFF_8001, 1'b1, 5'd7, 1'b0);
    sbq.push_back(held);
    tick();
    in_instr = {6'h04, 5'd1, 5'd2, 16'hFFFC};
    rd1_data = 32'd1; rd2_data = 32'd2;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL ori_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL ori_issue got=%h required=%h", obs, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle %0d got=%b required=0", i, in_ready); end
      n_cmp++; if (obs !== held) begin n_err++; $display("FAIL bp_hold cycle %0d got=%h required=%h", i, obs, held); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b required=1", in_ready); end
    sbq.push_back(mk(6'h04, 6'h3C, 32'd1, 32'd2, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0));
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL beq_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL beq_issue got=%h required=%h", obs, exp_v); end
    end
    tick();
    wb_en = 1'b1; wb_addr = 5'd7;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_r0_illegal();
    out_ready = 1'b1;
    in_instr = {6'h23, 5'd3, 5'd0, 16'h0004};
    rd1_data = 32'd40; rd2_data = 32'd0; in_valid = 1'b1;
    #1;
    sbq.push_back(mk(6'h23, 6'h04, 32'd40, 32'd0, 32'h4, 1'b0, 5'd0, 1'b0));
    tick();
    in_instr = {6'h3F, 5'd9, 5'd10, 16'h1234};
    rd1_data = 32'd9; rd2_data = 32'd10;
    #1;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL lw_r0 out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL lw_r0 got=%h required=%h", obs, exp_v); end
    end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL lw_r0_pending got=%h required=0", dut.pending); end
    sbq.push_back(mk(6'h3F, 6'h34, 32'd9, 32'd10, 32'h1234, 1'b0, 5'd0, 1'b1));
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL illegal_issue out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL illegal_issue got=%h required=%h", obs, exp_v); end
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_instr = {6'h08, 5'd0, 5'd2, 16'h0001};
    rd1_data = 32'd0; rd2_data = 32'd0; in_valid = 1'b1;
    #1;
    sbq.push_back(mk(6'h08, 6'h01, 32'd0, 32'd0, 32'h1, 1'b1, 5'd2, 1'b0));
    tick();
    in_instr = {6'h08, 5'd1, 5'd6, 16'h0003};
    rd1_data = 32'd3;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL addi_r2 out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL addi_r2 got=%h required=%h", obs, exp_v); end
    end
    sbq.push_back(mk(6'h08, 6'h03, 32'd3, 32'd0, 32'h3, 1'b1, 5'd6, 1'b0));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL addi_r6 out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL addi_r6 got=%h required=%h", obs, exp_v); end
    end
    n_cmp++; if (dut.pending !== 32'h44) begin n_err++; $display("FAIL flush_pre_pending got=%h required=00000044", dut.pending); end
    wb_en = 1'b1; wb_addr = 5'd9;
    tick();
    wb_en = 1'b0;
    n_cmp++; if (dut.pending !== 32'h44) begin n_err++; $display("FAIL wb_not_pending got=%h required=00000044", dut.pending); end
    flush = 1'b1; in_valid = 1'b1;
    in_instr = {6'h00, 5'd1, 5'd1, 5'd8, 5'd0, 6'h20};
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_blocks got=%b required=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got=%b required=0", out_valid); end
    n_cmp++; if (dut.pending !== 32'h4) begin n_err++; $display("FAIL flush_pending got=%h required=00000004", dut.pending); end
    wb_en = 1'b1; wb_addr = 5'd2;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_instr = {6'h08, 5'd0, 5'd5, 16'h0002};
    rd1_data = 32'd0; rd2_data = 32'd0; in_valid = 1'b1;
    #1;
    sbq.push_back(mk(6'h08, 6'h02, 32'd0, 32'd0, 32'h2, 1'b1, 5'd5, 1'b0));
    tick();
    in_instr = {6'h00, 5'd5, 5'd1, 5'd9, 5'd0, 6'h20};
    #1;
    n_cmp++;
    if (!out_valid || sbq.size() == 0) begin
      n_err++; $display("FAIL addi_r5 out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
    end else begin
      exp_v = sbq.pop_front();
      if (obs !== exp_v) begin n_err++; $display("FAIL addi_r5 got=%h required=%h", obs, exp_v); end
    end
    n_cmp++; if (dut.pending !== 32'h20) begin n_err++; $display("FAIL stall_pending got=%h required=00000020", dut.pending); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_stall got=%b required=0", in_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got=%b required=0", out_valid); end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL async_reset_pending got=%h required=0", dut.pending); end
    n_cmp++; if (obs !== exp_t'(0)) begin n_err++; $display("FAIL async_reset_fields got=%h required=0", obs); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b required=1", in_ready); end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    rd1_data = '0; rd2_data = '0; wb_en = 1'b0; wb_addr = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_rtype();
    test_back_to_back();
    test_backpressure();
    test_r0_illegal();
    test_flush();
    test_reset_mid_stall();
    n_cmp++; if (sbq.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d required=0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
